uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per serial bit period; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 8, TX byte FIFO entries; power of two, legal range 2..8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 wrtEn  input  1  bus write strobe from the memory-stage address decoder, one pulse per store.
REQ-006 addr  input  1  register select: 0 = data/status, 1 = control/config.
REQ-007 TxData  input  32  store data from the memory stage.
REQ-008 ReadReg  output  32  combinational register read data selected by addr.
REQ-009 SerialOut  output  1  registered UART TX line, idle high.

Function
REQ-010 A write with addr=0 SHALL push TxData[7:0] into the FIFO; TxData[31:8] are ignored.
REQ-011 A push SHALL be accepted if count<FIFO_DEPTH before the edge, or if a pop occurs on the same edge; otherwise it is dropped and sticky overflow is set to 1.
REQ-012 A write with addr=1 and TxData[0]=1 SHALL clear overflow; the FIFO, the FSM and other bits are unaffected.
REQ-013 ReadReg at addr=0 SHALL be {23'b0, PAR, count[3:0], overflow, full, empty, busy} in bits [31:9],[8],[7:4],[3],[2],[1],[0].
REQ-014 PAR SHALL be 1 when UART_TX_PARITY_EN is defined, else 0.
REQ-015 busy SHALL be 1 whenever the FSM is not IDLE.
REQ-016 ReadReg at addr=1 SHALL be CLKS_PER_BIT zero-extended to 32 bits.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY (only with the macro), and STOP.
REQ-018 IDLE->START SHALL occur on the first edge where count>0 before the edge; that edge pops the FIFO head into the shift register and drives SerialOut=0.
REQ-019 A push into an empty FIFO SHALL NOT pop on the same edge; SerialOut falls on the 2nd rising edge after the write edge, i.e. 1-cycle latency from write to start bit.
REQ-020 Each of START, each data bit, PARITY and STOP SHALL hold SerialOut for exactly CLKS_PER_BIT cycles, timed by the baud counter, which resets to 0 at every bit boundary.
REQ-021 DATA SHALL send 8 bits LSB first; the bit index runs 0..7, then the FSM moves to PARITY or STOP.
REQ-022 STOP SHALL drive SerialOut=1; at the end of STOP, if count>0 the FSM SHALL go directly to START with a pop (no idle gap), else to IDLE.
REQ-023 The FIFO SHALL use circular read/write pointers that wrap modulo FIFO_DEPTH, with count width log2(FIFO_DEPTH)+1.
REQ-024 full SHALL equal (count==FIFO_DEPTH), and empty SHALL equal (count==0).
REQ-025 Writes during an active frame SHALL NOT disturb the byte being shifted.

Reset
REQ-026 rst=1 SHALL immediately force SerialOut=1, FSM=IDLE, count=0, pointers=0, overflow=0, baud counter=0 and bit index=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no resumption; FIFO contents are discarded.
REQ-028 After reset, ReadReg at addr=0 SHALL read 0x00000002 without the macro and 0x00000102 with it.

Configuration
REQ-029 Macro UART_TX_PARITY_EN defined: the PARITY state is inserted between DATA and STOP, carrying even parity (XOR of the 8 data bits); a frame is 11 bit periods.
REQ-030 Macro UART_TX_PARITY_EN undefined: 8N1 framing; no PARITY state or logic; a frame is 10 bit periods.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-031 Single write 0x55 at addr 0 -> SerialOut low from the 2nd edge after the write for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then stop high 4 cycles; busy=0 after 40 cycles.
REQ-032 Three writes 0x01,0x02,0x03 on consecutive cycles -> three contiguous frames totalling 120 cycles with no idle-high gap between stop and next start.
REQ-033 Ten writes on consecutive cycles -> 9 accepted, 1 dropped; status shows full=1, overflow=1, count=8 after the 10th edge; 9 frames transmitted.
REQ-034 Write addr 1, TxData=0x1 after REQ-033 -> overflow=0; count and the ongoing transmission are unchanged.
REQ-035 rst asserted during data bit 3 of a frame -> SerialOut=1 with no clock edge; status 0x02; no further frames after rst deasserts.
REQ-036 Macro defined, write 0x07 -> parity bit 1 after bit 7; frame 44 cycles. Macro undefined -> frame 40 cycles.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Store-bus and serial-line bundle for uart_tx_fifo.
// master = memory-stage side, slave = UART.
interface uart_tx_fifo_if;
  logic        wrtEn;
  logic        addr;
  logic [31:0] TxData;
  logic [31:0] ReadReg;
  logic        SerialOut;

  modport master (
    output wrtEn, addr, TxData,
    input  ReadReg, SerialOut
  );

  modport slave (
    input  wrtEn, addr, TxData,
    output ReadReg, SerialOut
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Memory-mapped UART transmitter with a byte FIFO in front of a start/data/stop shifter.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit (8E1); default build is 8N1.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input logic            clk,
  input logic            rst,
  uart_tx_fifo_if.slave  bus
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = 16;
  localparam int unsigned BIT_W  = 3;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(7);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
  localparam logic PAR_FLAG = 1'b1;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
  localparam logic PAR_FLAG = 1'b0;
`endif

  state_e             state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [BIT_W-1:0]   bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               serial_q, serial_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               ovf_q, ovf_d;
`ifdef UART_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [7:0]         head;
  logic [BIT_W-1:0]   bit_nxt;
  logic               baud_end;
  logic               push, clr, accept, pop;
  logic               busy, full, empty;
  logic               unused_txdata;

  assign head          = mem_q[rd_ptr_q];
  assign bit_nxt       = bit_idx_q + BIT_W'(1);
  assign baud_end      = (baud_q == BAUD_LAST);
  assign push          = bus.wrtEn & ~bus.addr;
  assign clr           = bus.wrtEn & bus.addr & bus.TxData[0];
  assign busy          = (state_q != S_IDLE);
  assign full          = (cnt_q == CNT_FULL);
  assign empty         = (cnt_q == '0);
  assign unused_txdata = ^bus.TxData[31:8];

  // Frame sequencer: every bit period ends when the baud counter hits CLKS_PER_BIT-1.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    serial_d  = serial_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        baud_d    = '0;
        bit_idx_d = '0;
        serial_d  = 1'b1;
        if (cnt_q != '0) begin
          pop      = 1'b1;
          state_d  = S_START;
          serial_d = 1'b0;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
          serial_d  = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d  = S_PARITY;
            serial_d = parity_q;
`else
            state_d  = S_STOP;
            serial_d = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_nxt;
            serial_d  = shift_q[bit_nxt];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end) begin
          baud_d   = '0;
          state_d  = S_STOP;
          serial_d = 1'b1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          // Chain straight into the next start bit when more bytes are queued.
          if (cnt_q != '0) begin
            pop      = 1'b1;
            state_d  = S_START;
            serial_d = 1'b0;
          end else begin
            state_d  = S_IDLE;
            serial_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d  = S_IDLE;
        serial_d = 1'b1;
      end
    endcase
    if (pop) begin
      shift_d  = head;
`ifdef UART_TX_PARITY_EN
      parity_d = ^head;
`endif
    end
  end

  // FIFO bookkeeping: a full FIFO still takes a push when the same edge pops.
  always_comb begin
    accept   = push & ((cnt_q != CNT_FULL) | pop);
    cnt_d    = cnt_q + CNT_W'(accept) - CNT_W'(pop);
    wr_ptr_d = accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop    ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    ovf_d    = ovf_q;
    if (clr) begin
      ovf_d = 1'b0;
    end else if (push && !accept) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ovf_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      serial_q  <= serial_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ovf_q     <= ovf_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Storage needs no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= bus.TxData[7:0];
    end
  end

  assign bus.SerialOut = serial_q;
  assign bus.ReadReg   = bus.addr ? 32'(CLKS_PER_BIT)
                                  : {23'b0, PAR_FLAG, 4'(cnt_q), ovf_q, full, empty, busy};

endmodule
